// File: rtl/cpu_pkg.sv
// Shared CPU constants and the IF/ID payload type used by the fetch stage.
package cpu_pkg;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          IM_AW_DEF    = 10;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble overrides hold, hold overrides load.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   hold_i,
    input  logic   bubble_i,
    input  if_id_t d_i,
    output if_id_t q_o
);
    if_id_t q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        q_q <= IF_ID_BUBBLE;
        else if (bubble_i) q_q <= IF_ID_BUBBLE;
        else if (!hold_i)  q_q <= d_i;
    end

    assign q_o = q_q;
endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, next-PC select, IF/ID register and fetch counter.
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          IM_AW    = IM_AW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic             jmp,
    input  logic [31:0]      jmp_target,
    output logic [IM_AW-1:0] im_addr,
    input  logic [31:0]      im_dout,
    output logic [31:0]      pc,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic [31:0]      fetch_cnt
);
    logic [31:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] pc4;
    logic [31:0] tgt;
    logic        redirect, bubble, load;
    if_id_t      if_id_d, if_id_q;

    assign pc4      = pc_q + 32'd4;
    assign redirect = br_taken | jmp;
    assign tgt      = (br_taken ? br_target : jmp_target) & 32'hFFFF_FFFC;

    // A redirect blocked by stall is dropped entirely; it must not kill the held IF/ID.
    assign bubble = flush | (redirect & ~stall);
    assign load   = ~bubble & ~stall;

    always_comb begin
        pc_d = pc4;
        if (stall)         pc_d = pc_q;
        else if (redirect) pc_d = tgt;
    end

    assign cnt_d   = load ? cnt_q + 32'd1 : cnt_q;
    assign if_id_d = '{instr: im_dout, pc4: pc4, valid: 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            cnt_q <= 32'd0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

    if_id_reg u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold_i   (stall),
        .bubble_i (bubble),
        .d_i      (if_id_d),
        .q_o      (if_id_q)
    );

    assign pc          = pc_q;
    assign im_addr     = pc_q[IM_AW+1:2];
    assign if_id_instr = if_id_q.instr;
    assign if_id_pc4   = if_id_q.pc4;
    assign if_id_valid = if_id_q.valid;
    assign fetch_cnt   = cnt_q;
endmodule

// File: tb/tb_if_stage.sv
// Directed and randomized checks of if_stage against a cycle-level behavioural model.
module tb_if_stage;
    localparam int          IM_AW = 10;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic             clk, rst_n, stall, flush, br_taken, jmp;
    logic [31:0]      br_target, jmp_target, im_dout, pc;
    logic [31:0]      if_id_instr, if_id_pc4, fetch_cnt;
    logic             if_id_valid;
    logic [IM_AW-1:0] im_addr;

    logic [31:0] mem [0:(1<<IM_AW)-1];
    int tests = 0, failed = 0;

    // model state
    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    logic        m_valid;

    if_stage #(.RESET_PC(RPC), .IM_AW(IM_AW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .br_taken(br_taken), .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target),
        .im_addr(im_addr), .im_dout(im_dout), .pc(pc),
        .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
        .fetch_cnt(fetch_cnt)
    );

    assign im_dout = mem[im_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pc"},      pc,                  m_pc);
        chk({tag, ".im_addr"}, 32'(im_addr),        32'(m_pc[IM_AW+1:2]));
        chk({tag, ".instr"},   if_id_instr,         m_instr);
        chk({tag, ".pc4"},     if_id_pc4,           m_pc4);
        chk({tag, ".valid"},   32'(if_id_valid),    32'(m_valid));
        chk({tag, ".cnt"},     fetch_cnt,           m_cnt);
    endtask

    task automatic drive(input logic s, input logic f, input logic b, input logic [31:0] bt,
                         input logic j, input logic [31:0] jt);
        stall = s; flush = f; br_taken = b; br_target = bt; jmp = j; jmp_target = jt;
    endtask

    task automatic model_reset();
        m_pc = RPC; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
    endtask

    // One clock edge: model computes from the pre-edge PC, then the DUT is compared.
    task automatic step(input string tag);
        logic        redir, kill;
        logic [31:0] target, old_pc;
        redir  = br_taken || jmp;
        target = br_taken ? br_target : jmp_target;
        target = {target[31:2], 2'b00};
        kill   = flush || (redir && !stall);
        old_pc = m_pc;
        if (kill) begin
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (!stall) begin
            m_instr = mem[old_pc[IM_AW+1:2]]; m_pc4 = old_pc + 32'd4; m_valid = 1'b1;
            m_cnt   = m_cnt + 32'd1;
        end
        if (!stall) m_pc = redir ? target : old_pc + 32'd4;
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic hard_reset();
        drive(0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_model("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < (1 << IM_AW); i++) mem[i] = $urandom;
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #3;

        // reset then free running
        hard_reset();
        chk("rst_pc", pc, RPC);
        step("run1"); chk("run1_pc", pc, 32'h4); chk("run1_pc4", if_id_pc4, 32'h4);
        chk("run1_instr", if_id_instr, mem[0]);
        step("run2"); chk("run2_pc", pc, 32'h8);
        step("run3"); chk("run3_pc", pc, 32'hC); chk("run3_pc4", if_id_pc4, 32'hC);
        chk("run3_cnt", fetch_cnt, 32'd3);

        // taken branch at pc=8
        hard_reset();
        step("b0"); step("b1");
        chk("b_at8", pc, 32'h8);
        drive(0, 0, 1, 32'h40, 0, 0); step("br");
        chk("br_pc", pc, 32'h40); chk("br_valid", 32'(if_id_valid), 0); chk("br_instr", if_id_instr, 0);
        drive(0, 0, 0, 0, 0, 0); step("br_next");
        chk("br_next_instr", if_id_instr, mem[16]); chk("br_next_pc4", if_id_pc4, 32'h44);

        // branch beats jump when both set
        drive(0, 0, 1, 32'h100, 1, 32'h200); step("prio");
        chk("prio_pc", pc, 32'h100);

        // stall for 2 cycles at pc=0x10
        drive(0, 0, 0, 0, 1, 32'hC); step("toC");
        drive(0, 0, 0, 0, 0, 0); step("to10");
        chk("at10", pc, 32'h10);
        drive(1, 0, 0, 0, 0, 0); step("st1"); step("st2");
        chk("st_pc", pc, 32'h10); chk("st_pc4", if_id_pc4, 32'h10); chk("st_cnt", fetch_cnt, m_cnt);

        // stall beats jump; flush with stall gives bubble
        drive(1, 0, 0, 0, 1, 32'h80); step("stj");
        chk("stj_pc", pc, 32'h10); chk("stj_valid", 32'(if_id_valid), 1);
        drive(1, 1, 0, 0, 0, 0); step("stf");
        chk("stf_pc", pc, 32'h10); chk("stf_valid", 32'(if_id_valid), 0);

        // plain flush advances pc
        drive(0, 0, 0, 0, 0, 0); step("pre_fl");
        drive(0, 1, 0, 0, 0, 0); step("fl");
        chk("fl_valid", 32'(if_id_valid), 0);

        // misaligned target and wrap
        drive(0, 0, 0, 0, 1, 32'h83); step("j83");
        chk("j83_pc", pc, 32'h80);
        drive(0, 0, 0, 0, 1, 32'hFFFF_FFFC); step("jtop");
        chk("top_imaddr", 32'(im_addr), 32'h3FF);
        drive(0, 0, 0, 0, 0, 0); step("wrap");
        chk("wrap_pc", pc, 32'h0); chk("wrap_pc4", if_id_pc4, 32'h0);
        chk("wrap_instr", if_id_instr, mem[1023]);

        // async reset mid-stall with a pending redirect
        drive(0, 0, 0, 0, 1, 32'h20); step("j20");
        drive(1, 0, 0, 0, 1, 32'h300);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("ares_pc", pc, RPC); chk("ares_valid", 32'(if_id_valid), 0); chk("ares_cnt", fetch_cnt, 0);
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk); rst_n = 1'b1;
        step("post_rst");
        chk("post_rst_pc", pc, RPC + 32'd4); chk("post_rst_valid", 32'(if_id_valid), 1);
        chk("post_rst_instr", if_id_instr, mem[0]);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0, $urandom,
                  $urandom_range(0, 7) == 0, ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 4095)));
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter IM_AW, default 10, word-address width driven to instruction memory (byte addr bits [IM_AW+1:2]).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 stall  in  1  hazard-unit hold; freezes PC and IF/ID register.
REQ-006 flush  in  1  replaces IF/ID contents with a bubble.
REQ-007 br_taken  in  1  branch resolved taken in ID.
REQ-008 br_target  in  32  branch target byte address.
REQ-009 jmp  in  1  jump/jr resolved in ID.
REQ-010 jmp_target  in  32  jump target byte address.
REQ-011 im_addr  out  IM_AW  word address to instruction memory = pc[IM_AW+1:2].
REQ-012 im_dout  in  32  instruction word; combinational response to im_addr in the same cycle.
REQ-013 pc  out  32  current fetch PC.
REQ-014 if_id_instr  out  32  registered instruction for ID.
REQ-015 if_id_pc4  out  32  registered PC+4 of that instruction.
REQ-016 if_id_valid  out  1  1 = IF/ID holds a real instruction, 0 = bubble.
REQ-017 fetch_cnt  out  32  count of valid instructions loaded into IF/ID.

Function
REQ-018 Redirect = br_taken | jmp; when both are set, br_target has priority over jmp_target.
REQ-019 Next PC priority: stall (hold pc) > redirect (target with bits [1:0] forced to 0) > pc+4.
REQ-020 stall together with redirect: stall wins; the redirect is dropped, and the hazard unit reasserts it on a later cycle.
REQ-021 pc+4 wraps modulo 2^32; im_addr aliases above the IM_AW window with no error indication.
REQ-022 IF/ID update priority: flush or accepted redirect (bubble) > stall (hold) > load {im_dout, pc+4, valid=1}.
REQ-023 Bubble = if_id_instr 32'h0000_0000 (NOP), if_id_pc4 32'h0, if_id_valid 0.
REQ-024 flush together with stall: IF/ID takes the bubble; pc holds.
REQ-025 Fetch latency: an instruction at pc in cycle N appears on if_id_* in cycle N+1.
REQ-026 Taken redirect costs exactly one bubble; no branch delay slot.
REQ-027 fetch_cnt increments by 1 on each edge that loads a valid instruction into IF/ID, and wraps at 2^32.
REQ-028 No combinational path from stall/flush/redirect to if_id_* outputs; pc and im_addr depend on registers only.

Reset
REQ-029 On rst_n low, immediately and asynchronously: pc = RESET_PC, IF/ID = bubble, fetch_cnt = 0.
REQ-030 First edge after rst_n deasserts loads IF/ID with the instruction at RESET_PC (valid=1), unless stall or flush is set.
REQ-031 Reset mid-stall or mid-redirect discards all pending state; no redirect survives reset.

Structure
REQ-032 Shared package cpu_pkg holds NOP_INSTR, the RESET_PC default and the IM_AW default.
REQ-033 Sub-module if_id_reg implements the IF/ID register with hold/bubble controls; the PC logic and next-PC mux stay in if_stage.

Verification
REQ-034 Reset then 4 free-running cycles -> pc 0,4,8,C; if_id_pc4 4,8,C with valid=1; fetch_cnt=3.
REQ-035 br_taken=1, br_target=32'h40 at pc=8 -> next pc=0x40, one bubble (valid=0, instr=0); the following cycle carries the instruction at 0x40.
REQ-036 stall held 2 cycles at pc=0x10 -> pc stays 0x10, if_id_* unchanged, fetch_cnt unchanged.
REQ-037 stall=1 with jmp=1, jmp_target=0x80 -> pc holds; flush=1 with stall=1 -> bubble loaded, pc holds.
REQ-038 jmp_target=32'h83 -> pc=0x80; with pc=32'hFFFF_FFFC and no events -> pc wraps to 0.
REQ-039 rst_n asserted while stall=1 at pc=0x20 -> pc=RESET_PC and valid=0 immediately, without a clock edge.
